// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU function codes, opcode/funct encodings and the
// decoded control bundle used by the ID/EX stage and the ALU.
package mips_pkg;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_sel_e;

  typedef struct packed {
    logic     legal;
    alu_op_e  alu_op;
    imm_sel_e imm_sel;
    logic     dest_rt;
    logic     reads_rt;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
  } ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding for one ALU source: EX/MEM result beats MEM/WB result,
// otherwise the register-file value; register 0 is never forwarded.
module forward_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] reg_data,
  input  logic              exmem_wr,
  input  logic [AWIDTH-1:0] exmem_rd,
  input  logic [DWIDTH-1:0] exmem_value,
  input  logic              memwb_wr,
  input  logic [AWIDTH-1:0] memwb_rd,
  input  logic [DWIDTH-1:0] memwb_value,
  output logic [DWIDTH-1:0] data
);

  always_comb begin
    data = reg_data;
    if (addr != '0) begin
      if (exmem_wr && (exmem_rd == addr)) begin
        data = exmem_value;
      end else if (memwb_wr && (memwb_rd == addr)) begin
        data = memwb_value;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes opcode/funct into ALU control, registers
// operands, forwards late results and stalls on load-use hazards.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              de_clk,
  input  logic              de_rst,
  input  logic              de_i_valid,
  output logic              de_o_ready,
  input  logic [5:0]        de_i_opcode,
  input  logic [5:0]        de_i_funct,
  input  logic [AWIDTH-1:0] de_i_rs_addr,
  input  logic [AWIDTH-1:0] de_i_rt_addr,
  input  logic [AWIDTH-1:0] de_i_rd_addr,
  input  logic [DWIDTH-1:0] de_i_data_rs,
  input  logic [DWIDTH-1:0] de_i_data_rt,
  input  logic [15:0]       de_i_imm,
  input  logic              de_i_flush,
  input  logic              de_i_hold,
  input  logic              de_i_exmem_wr,
  input  logic [AWIDTH-1:0] de_i_exmem_rd,
  input  logic [DWIDTH-1:0] de_i_exmem_value,
  input  logic              de_i_memwb_wr,
  input  logic [AWIDTH-1:0] de_i_memwb_rd,
  input  logic [DWIDTH-1:0] de_i_memwb_value,
  output logic              de_o_valid,
  output logic [DWIDTH-1:0] de_o_data_rs,
  output logic [DWIDTH-1:0] de_o_data_rt,
  output logic [3:0]        de_o_funct,
  output logic [DWIDTH-1:0] de_o_store_data,
  output logic [AWIDTH-1:0] de_o_wr_addr,
  output logic              de_o_reg_write,
  output logic              de_o_mem_read,
  output logic              de_o_mem_write,
  output logic              de_o_illegal
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        funct;
    logic [AWIDTH-1:0] rs_addr;
    logic [AWIDTH-1:0] rt_addr;
    logic [DWIDTH-1:0] data_rs;
    logic [DWIDTH-1:0] data_rt;
    logic [DWIDTH-1:0] imm_ext;
    logic              use_imm;
    logic [AWIDTH-1:0] wr_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              illegal;
  } stage_t;

  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    c.alu_op  = ALU_ADD;
    c.imm_sel = IMM_NONE;
    case (op)
      OP_RTYPE: begin
        c.legal     = 1'b1;
        c.reads_rt  = 1'b1;
        c.reg_write = 1'b1;
        case (fn)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = '0;
        endcase
      end
      OP_ADDI: begin
        c.legal = 1'b1; c.imm_sel = IMM_SEXT; c.dest_rt = 1'b1; c.reg_write = 1'b1;
      end
      OP_ANDI: begin
        c.legal = 1'b1; c.alu_op = ALU_AND; c.imm_sel = IMM_ZEXT;
        c.dest_rt = 1'b1; c.reg_write = 1'b1;
      end
      OP_ORI: begin
        c.legal = 1'b1; c.alu_op = ALU_OR; c.imm_sel = IMM_ZEXT;
        c.dest_rt = 1'b1; c.reg_write = 1'b1;
      end
      OP_LW: begin
        c.legal = 1'b1; c.imm_sel = IMM_SEXT; c.dest_rt = 1'b1;
        c.reg_write = 1'b1; c.mem_read = 1'b1;
      end
      OP_SW: begin
        c.legal = 1'b1; c.imm_sel = IMM_SEXT; c.reads_rt = 1'b1; c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.legal = 1'b1; c.alu_op = ALU_SUB; c.reads_rt = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  stage_t stage_q;
  stage_t stage_d;
  ctrl_t  dec;
  logic   load_use;
  logic [DWIDTH-1:0] fwd_rs;
  logic [DWIDTH-1:0] fwd_rt;

  assign dec = decode(de_i_opcode, de_i_funct);

  // Only a live load can create the hazard; it writes the rt field as destination.
  assign load_use = stage_q.valid && stage_q.mem_read && (stage_q.wr_addr != '0) &&
                    de_i_valid &&
                    ((de_i_rs_addr == stage_q.wr_addr) ||
                     (dec.reads_rt && (de_i_rt_addr == stage_q.wr_addr)));

  assign de_o_ready = !de_i_hold && !load_use;

  always_comb begin
    stage_d = '0;
    if (de_i_flush) begin
      stage_d = '0;
    end else if (de_i_hold) begin
      stage_d         = stage_q;
      stage_d.illegal = 1'b0;
    end else if (!load_use && de_i_valid) begin
      if (dec.legal) begin
        stage_d.valid     = 1'b1;
        stage_d.funct     = dec.alu_op;
        stage_d.rs_addr   = de_i_rs_addr;
        stage_d.rt_addr   = de_i_rt_addr;
        stage_d.data_rs   = de_i_data_rs;
        stage_d.data_rt   = de_i_data_rt;
        stage_d.use_imm   = (dec.imm_sel != IMM_NONE);
        stage_d.imm_ext   = (dec.imm_sel == IMM_SEXT) ?
                            {{(DWIDTH-16){de_i_imm[15]}}, de_i_imm} :
                            {{(DWIDTH-16){1'b0}}, de_i_imm};
        stage_d.wr_addr   = !dec.reg_write ? '0 :
                            (dec.dest_rt ? de_i_rt_addr : de_i_rd_addr);
        stage_d.reg_write = dec.reg_write;
        stage_d.mem_read  = dec.mem_read;
        stage_d.mem_write = dec.mem_write;
      end else begin
        stage_d.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge de_clk) begin
    if (!de_rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  forward_unit #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwd_rs (
    .addr        (stage_q.rs_addr),
    .reg_data    (stage_q.data_rs),
    .exmem_wr    (de_i_exmem_wr),
    .exmem_rd    (de_i_exmem_rd),
    .exmem_value (de_i_exmem_value),
    .memwb_wr    (de_i_memwb_wr),
    .memwb_rd    (de_i_memwb_rd),
    .memwb_value (de_i_memwb_value),
    .data        (fwd_rs)
  );

  forward_unit #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwd_rt (
    .addr        (stage_q.rt_addr),
    .reg_data    (stage_q.data_rt),
    .exmem_wr    (de_i_exmem_wr),
    .exmem_rd    (de_i_exmem_rd),
    .exmem_value (de_i_exmem_value),
    .memwb_wr    (de_i_memwb_wr),
    .memwb_rd    (de_i_memwb_rd),
    .memwb_value (de_i_memwb_value),
    .data        (fwd_rt)
  );

  assign de_o_valid      = stage_q.valid;
  assign de_o_data_rs    = fwd_rs;
  assign de_o_data_rt    = stage_q.use_imm ? stage_q.imm_ext : fwd_rt;
  assign de_o_store_data = fwd_rt;
  assign de_o_funct      = stage_q.funct;
  assign de_o_wr_addr    = stage_q.wr_addr;
  assign de_o_reg_write  = stage_q.reg_write;
  assign de_o_mem_read   = stage_q.mem_read;
  assign de_o_mem_write  = stage_q.mem_write;
  assign de_o_illegal    = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic, all checked
// against an instruction-level reference model.
module tb_id_ex_stage;

  logic        de_clk = 1'b0;
  logic        de_rst;
  logic        de_i_valid;
  logic        de_o_ready;
  logic [5:0]  de_i_opcode, de_i_funct;
  logic [4:0]  de_i_rs_addr, de_i_rt_addr, de_i_rd_addr;
  logic [31:0] de_i_data_rs, de_i_data_rt;
  logic [15:0] de_i_imm;
  logic        de_i_flush, de_i_hold;
  logic        de_i_exmem_wr, de_i_memwb_wr;
  logic [4:0]  de_i_exmem_rd, de_i_memwb_rd;
  logic [31:0] de_i_exmem_value, de_i_memwb_value;
  logic        de_o_valid;
  logic [31:0] de_o_data_rs, de_o_data_rt, de_o_store_data;
  logic [3:0]  de_o_funct;
  logic [4:0]  de_o_wr_addr;
  logic        de_o_reg_write, de_o_mem_read, de_o_mem_write, de_o_illegal;

  int n_checks = 0;
  int n_err    = 0;

  always #5 de_clk = ~de_clk;

  id_ex_stage dut (
    .de_clk(de_clk), .de_rst(de_rst), .de_i_valid(de_i_valid), .de_o_ready(de_o_ready),
    .de_i_opcode(de_i_opcode), .de_i_funct(de_i_funct),
    .de_i_rs_addr(de_i_rs_addr), .de_i_rt_addr(de_i_rt_addr), .de_i_rd_addr(de_i_rd_addr),
    .de_i_data_rs(de_i_data_rs), .de_i_data_rt(de_i_data_rt), .de_i_imm(de_i_imm),
    .de_i_flush(de_i_flush), .de_i_hold(de_i_hold),
    .de_i_exmem_wr(de_i_exmem_wr), .de_i_exmem_rd(de_i_exmem_rd), .de_i_exmem_value(de_i_exmem_value),
    .de_i_memwb_wr(de_i_memwb_wr), .de_i_memwb_rd(de_i_memwb_rd), .de_i_memwb_value(de_i_memwb_value),
    .de_o_valid(de_o_valid), .de_o_data_rs(de_o_data_rs), .de_o_data_rt(de_o_data_rt),
    .de_o_funct(de_o_funct), .de_o_store_data(de_o_store_data), .de_o_wr_addr(de_o_wr_addr),
    .de_o_reg_write(de_o_reg_write), .de_o_mem_read(de_o_mem_read),
    .de_o_mem_write(de_o_mem_write), .de_o_illegal(de_o_illegal)
  );

  // Reference model: the instruction currently held in EX, as raw fields.
  typedef struct {
    bit        v;
    bit        ill;
    bit [5:0]  op, fn;
    bit [4:0]  rs, rt, rd;
    bit [31:0] drs, drt;
    bit [15:0] imm;
  } ins_t;

  ins_t m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic string mnem(input bit [5:0] op, input bit [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h20: return "ADD";
               6'h22: return "SUB";
               6'h24: return "AND";
               6'h25: return "OR";
               6'h2A: return "SLT";
               default: return "ILL";
             endcase
      6'h08: return "ADDI";
      6'h0C: return "ANDI";
      6'h0D: return "ORI";
      6'h23: return "LW";
      6'h2B: return "SW";
      6'h04: return "BEQ";
      default: return "ILL";
    endcase
  endfunction

  function automatic bit is_rtype(input string n);
    return n == "ADD" || n == "SUB" || n == "AND" || n == "OR" || n == "SLT";
  endfunction

  function automatic bit [3:0] alu_code(input string n);
    if (n == "ADD" || n == "ADDI" || n == "LW" || n == "SW") return 4'd0;
    if (n == "SUB" || n == "BEQ") return 4'd1;
    if (n == "AND" || n == "ANDI") return 4'd2;
    if (n == "OR"  || n == "ORI")  return 4'd3;
    if (n == "SLT") return 4'd4;
    return 4'd0;
  endfunction

  function automatic bit [31:0] fwd(input bit [4:0] a, input bit [31:0] rv);
    if (a == 0) return rv;
    if (de_i_exmem_wr && de_i_exmem_rd == a) return de_i_exmem_value;
    if (de_i_memwb_wr && de_i_memwb_rd == a) return de_i_memwb_value;
    return rv;
  endfunction

  function automatic bit model_ready();
    string cur, inc;
    bit    hazard;
    cur = m.v ? mnem(m.op, m.fn) : "BUB";
    inc = mnem(de_i_opcode, de_i_funct);
    hazard = (cur == "LW") && (m.rt != 0) && de_i_valid &&
             ((de_i_rs_addr == m.rt) ||
              ((is_rtype(inc) || inc == "SW" || inc == "BEQ") && de_i_rt_addr == m.rt));
    return !de_i_hold && !hazard;
  endfunction

  task automatic check_all();
    string     n;
    bit [31:0] e_rs, e_rt, e_st;
    bit        e_rw, e_mr, e_mw;
    bit [4:0]  e_wa;
    bit [3:0]  e_fn;
    n = m.v ? mnem(m.op, m.fn) : "BUB";
    e_rs = m.v ? fwd(m.rs, m.drs) : 32'd0;
    e_st = m.v ? fwd(m.rt, m.drt) : 32'd0;
    if (n == "ADDI" || n == "LW" || n == "SW") e_rt = {{16{m.imm[15]}}, m.imm};
    else if (n == "ANDI" || n == "ORI")        e_rt = {16'h0, m.imm};
    else                                        e_rt = e_st;
    e_rw = is_rtype(n) || n == "ADDI" || n == "ANDI" || n == "ORI" || n == "LW";
    e_mr = (n == "LW");
    e_mw = (n == "SW");
    e_wa = is_rtype(n) ? m.rd : (e_rw ? m.rt : 5'd0);
    e_fn = m.v ? alu_code(n) : 4'd0;
    chk("ready",      de_o_ready,      model_ready());
    chk("valid",      de_o_valid,      m.v);
    chk("funct",      de_o_funct,      e_fn);
    chk("data_rs",    de_o_data_rs,    e_rs);
    chk("data_rt",    de_o_data_rt,    e_rt);
    chk("store_data", de_o_store_data, e_st);
    chk("wr_addr",    de_o_wr_addr,    e_wa);
    chk("reg_write",  de_o_reg_write,  e_rw);
    chk("mem_read",   de_o_mem_read,   e_mr);
    chk("mem_write",  de_o_mem_write,  e_mw);
    chk("illegal",    de_o_illegal,    m.ill);
  endtask

  // One cycle: inputs already driven at the falling edge; check, clock, update model.
  task automatic step();
    bit rdy;
    #1;
    check_all();
    rdy = model_ready();
    @(posedge de_clk);
    if (!de_rst || de_i_flush) m = '{default: 0};
    else if (de_i_hold) m.ill = 0;
    else if (de_i_valid && rdy) begin
      if (mnem(de_i_opcode, de_i_funct) == "ILL") begin
        m = '{default: 0};
        m.ill = 1;
      end else begin
        m = '{v: 1, ill: 0, op: de_i_opcode, fn: de_i_funct, rs: de_i_rs_addr,
              rt: de_i_rt_addr, rd: de_i_rd_addr, drs: de_i_data_rs,
              drt: de_i_data_rt, imm: de_i_imm};
      end
    end else m = '{default: 0};
    @(negedge de_clk);
  endtask

  task automatic clr_in();
    de_rst = 1'b1; de_i_valid = 0; de_i_opcode = 0; de_i_funct = 0;
    de_i_rs_addr = 0; de_i_rt_addr = 0; de_i_rd_addr = 0;
    de_i_data_rs = 0; de_i_data_rt = 0; de_i_imm = 0;
    de_i_flush = 0; de_i_hold = 0;
    de_i_exmem_wr = 0; de_i_exmem_rd = 0; de_i_exmem_value = 0;
    de_i_memwb_wr = 0; de_i_memwb_rd = 0; de_i_memwb_value = 0;
  endtask

  task automatic set_ins(input bit [5:0] op, input bit [5:0] fn, input bit [4:0] rs,
                         input bit [4:0] rt, input bit [4:0] rd, input bit [31:0] drs,
                         input bit [31:0] drt, input bit [15:0] imm);
    de_i_valid = 1; de_i_opcode = op; de_i_funct = fn;
    de_i_rs_addr = rs; de_i_rt_addr = rt; de_i_rd_addr = rd;
    de_i_data_rs = drs; de_i_data_rt = drt; de_i_imm = imm;
  endtask

  bit [5:0] ops [11] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h01};
  bit [5:0] fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

  initial begin
    clr_in();
    de_rst = 0;
    m = '{default: 0};
    @(posedge de_clk);
    @(negedge de_clk);
    step();
    chk("reset_valid", de_o_valid, 1'b0);

    // ADD, no forwarding
    clr_in();
    set_ins(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd4, 16'h0);
    step();
    clr_in(); #1;
    chk("add_funct", de_o_funct, 4'd0);
    chk("add_rs", de_o_data_rs, 32'd5);
    chk("add_rt", de_o_data_rt, 32'd4);
    chk("add_rw", de_o_reg_write, 1'b1);
    chk("add_wa", de_o_wr_addr, 5'd3);

    // immediate extension
    set_ins(6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 32'd9, 32'd9, 16'hFFFF);
    step();
    clr_in(); #1;
    chk("ori_imm", de_o_data_rt, 32'h0000FFFF);
    chk("ori_funct", de_o_funct, 4'd3);
    set_ins(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'd9, 32'd9, 16'hFFFF);
    step();
    clr_in(); #1;
    chk("addi_imm", de_o_data_rt, 32'hFFFFFFFF);

    // forwarding priority and register 0
    set_ins(6'h00, 6'h20, 5'd3, 5'd0, 5'd1, 32'd7, 32'd0, 16'h0);
    step();
    clr_in();
    de_i_exmem_wr = 1; de_i_exmem_rd = 5'd3; de_i_exmem_value = 32'd100;
    de_i_memwb_wr = 1; de_i_memwb_rd = 5'd3; de_i_memwb_value = 32'd200;
    #1 chk("fwd_exmem", de_o_data_rs, 32'd100);
    de_i_exmem_wr = 0;
    #1 chk("fwd_memwb", de_o_data_rs, 32'd200);
    clr_in();
    set_ins(6'h00, 6'h20, 5'd0, 5'd0, 5'd1, 32'd9, 32'd0, 16'h0);
    step();
    clr_in();
    de_i_exmem_wr = 1; de_i_exmem_rd = 5'd0; de_i_exmem_value = 32'd100;
    de_i_memwb_wr = 1; de_i_memwb_rd = 5'd0; de_i_memwb_value = 32'd200;
    #1 chk("fwd_r0", de_o_data_rs, 32'd9);
    clr_in();

    // load-use stall
    set_ins(6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 32'd0, 32'd0, 16'h4);
    step();
    set_ins(6'h00, 6'h20, 5'd7, 5'd2, 5'd4, 32'd1, 32'd2, 16'h0);
    #1 chk("lu_ready", de_o_ready, 1'b0);
    step();
    chk("lu_bubble", de_o_valid, 1'b0);
    chk("lu_ready2", de_o_ready, 1'b1);
    step();
    chk("lu_accept", de_o_valid, 1'b1);

    // flush with hold
    de_i_flush = 1; de_i_hold = 1;
    step();
    chk("flush_hold", de_o_valid, 1'b0);
    clr_in();

    // illegal opcode pulse
    set_ins(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
    step();
    clr_in(); #1;
    chk("ill_pulse", de_o_illegal, 1'b1);
    chk("ill_valid", de_o_valid, 1'b0);
    step();
    chk("ill_clear", de_o_illegal, 1'b0);

    // reset during hold
    set_ins(6'h00, 6'h22, 5'd1, 5'd2, 5'd3, 32'd11, 32'd12, 16'h0);
    step();
    de_i_hold = 1; de_rst = 0;
    step();
    chk("rst_valid", de_o_valid, 1'b0);
    chk("rst_rs", de_o_data_rs, 32'd0);
    clr_in();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      de_rst       = ($urandom_range(0, 99) >= 2);
      de_i_valid   = ($urandom_range(0, 99) < 80);
      de_i_opcode  = ops[$urandom_range(0, 10)];
      de_i_funct   = fns[$urandom_range(0, 5)];
      de_i_rs_addr = 5'($urandom_range(0, 3));
      de_i_rt_addr = 5'($urandom_range(0, 3));
      de_i_rd_addr = 5'($urandom_range(0, 3));
      de_i_data_rs = $urandom;
      de_i_data_rt = $urandom;
      de_i_imm     = 16'($urandom);
      de_i_flush   = ($urandom_range(0, 99) < 8);
      de_i_hold    = ($urandom_range(0, 99) < 15);
      de_i_exmem_wr = 1'($urandom); de_i_exmem_rd = 5'($urandom_range(0, 3));
      de_i_exmem_value = $urandom;
      de_i_memwb_wr = 1'($urandom); de_i_memwb_rd = 5'($urandom_range(0, 3));
      de_i_memwb_value = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the MIPS core, directly upstream of the ALU. It translates opcode/funct into the 4-bit ALU function code, registers operands and control for one cycle, and forwards results from EX/MEM and MEM/WB into the ALU operand inputs. It detects load-use hazards, inserts bubbles, and honours flush and downstream hold.

## Interface
- DWIDTH, 32, datapath width
- AWIDTH, 5, register address width
- de_clk  in  1  clock, all state updates on rising edge
- de_rst  in  1  reset: synchronous and active-low
- de_i_valid  in  1  decode presents an instruction
- de_o_ready  out  1  stage accepts this cycle (comb.)
- de_i_opcode / de_i_funct  in  6 / 6  instruction fields
- de_i_rs_addr / de_i_rt_addr / de_i_rd_addr  in  AWIDTH  register indices
- de_i_data_rs / de_i_data_rt  in  DWIDTH  register-file read data
- de_i_imm  in  16  immediate field
- de_i_flush  in  1  kill the registered instruction (branch taken)
- de_i_hold  in  1  downstream stall, freeze stage
- de_i_exmem_wr / de_i_exmem_rd / de_i_exmem_value  in  1 / AWIDTH / DWIDTH  EX/MEM writeback info
- de_i_memwb_wr / de_i_memwb_rd / de_i_memwb_value  in  1 / AWIDTH / DWIDTH  MEM/WB writeback info
- de_o_valid  out  1  registered instruction valid
- de_o_data_rs / de_o_data_rt  out  DWIDTH  ALU operands (to a_i_data_rs / a_i_data_rt)
- de_o_funct  out  4  ALU function (to a_i_funct)
- de_o_store_data  out  DWIDTH  forwarded rt for SW
- de_o_wr_addr  out  AWIDTH  destination register
- de_o_reg_write / de_o_mem_read / de_o_mem_write  out  1  control
- de_o_illegal  out  1  one-cycle pulse: unsupported opcode/funct accepted

## Operation
- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- R-type (opcode 0x00): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; dest rd, reg_write=1.
- ADDI 0x08: ADD, sign-extended imm, dest rt. ANDI 0x0C / ORI 0x0D: AND / OR, zero-extended imm, dest rt.
- LW 0x23: ADD, sign-ext imm, mem_read, dest rt. SW 0x2B: ADD, sign-ext imm, mem_write, no reg_write. BEQ 0x04: SUB, no write.
- Any other encoding: loaded as bubble (valid 0, all control 0), de_o_illegal=1 for one cycle.
- Forwarding (comb. on registered rs/rt addr): EX/MEM match (wr=1, rd==addr, addr!=0) wins over MEM/WB match; else registered file data. Address 0 never forwarded.
- de_o_data_rt = extended imm for I-type ALU/LW/SW, else forwarded rt. de_o_store_data = forwarded rt always.
- Load-use: registered valid LW with dest X, incoming valid instruction reads X (rs, or rt for R-type/SW/BEQ), X!=0 -> de_o_ready=0, bubble loaded, decode holds instruction.
- Update priority per edge: reset > flush > hold > load-use bubble > accept (valid&ready) > bubble.

## Timing
- Reset (de_rst=0 at edge): de_o_valid, all control, de_o_illegal, registered data/addr/funct = 0; forwarded outputs therefore 0.
- Latency 1 cycle: instruction accepted at edge N is on outputs after N.
- de_o_ready = !de_i_hold && !load_use; comb., no dependence on de_i_flush.
- Flush: registered contents become bubble; concurrent incoming instruction is dropped (decode is also flushed by the branch unit).
- Hold: all registers keep value; de_o_illegal cleared after one cycle even under hold.
- Flush with hold: flush wins. Reset mid-hold/stall: clears everything, no residual bubble count.
- Forwarding is combinational from current EX/MEM and MEM/WB inputs, updates every cycle including under hold.

## Structure
- Shared package mips_pkg: ALU codes, opcode/funct constants, control-bundle typedef; shared with alu.
- Sub-module forward_unit (one instance per operand): two-source priority match and mux.
- Decode table is a combinational function inside this block.

## Test plan
- ADD rs=5, rt=4 accepted, no forwarding -> next cycle de_o_funct=0, operands 5/4, reg_write=1, wr_addr=rd.
- ORI rt=$2, imm 0xFFFF -> de_o_data_rt=0x0000FFFF, funct=3; ADDI imm 0xFFFF -> 0xFFFFFFFF.
- rs=$3 with EX/MEM(wr,$3,100) and MEM/WB(wr,$3,200) -> de_o_data_rs=100; rs=$0 with both matching $0 -> register value.
- LW $7 then ADD rs=$7 -> ready=0 one cycle, one bubble (valid 0), ADD accepted next cycle.
- Flush and hold asserted together with valid instruction -> de_o_valid=0 after edge.
- Opcode 0x3F -> de_o_illegal=1 one cycle, de_o_valid=0; reset mid-stream -> all outputs 0.
